reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
- Shares the single internal register bus between N_REQ requesters, e.g. the UART write-packet controller and a UART read-packet controller.
- Grants requesters round-robin and issues one bus transaction at a time.
- Waits for read data up to a timeout, then returns an acknowledge with read data or an error to the granted requester.
- Sits between the UART packet controllers and the register block.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- ADDR_W, 8, register address width
- DATA_W, 32, register data width
- TIMEOUT, 16, max cycles in WAIT_RD before an error response (>=1)

Ports:
- ipClk  input  1  system clock
- ipReset  input  1  synchronous, active-low reset
- ipReq  input  N_REQ  per-requester request; held high until the matching opAck
- ipWrite  input  N_REQ  per-requester op: 1=write, 0=read
- ipAddress  input  N_REQ*ADDR_W  per-requester address; requester i uses slice [i*ADDR_W +: ADDR_W]
- ipWrData  input  N_REQ*DATA_W  per-requester write data; same slicing
- opAck  output  N_REQ  one-hot, one-cycle completion pulse
- opError  output  1  valid with opAck; 1 = read timed out
- opRdData  output  DATA_W  valid with opAck on a read
- opBusy  output  1  high whenever state != IDLE
- opBusValid  output  1  one-cycle register bus strobe
- opBusWrite  output  1  bus op, valid with opBusValid
- opBusAddress  output  ADDR_W  bus address
- opBusWrData  output  DATA_W  bus write data
- ipBusRdValid  input  1  read data strobe from the register block
- ipBusRdData  input  DATA_W  read data

Behaviour:
- Reset (ipReset==0 at a clock edge):
  - state=IDLE
  - opAck=0, opError=0, opRdData=0, opBusy=0
  - opBusValid=0, opBusWrite=0, opBusAddress=0, opBusWrData=0
  - last-grant pointer = N_REQ-1, so requester 0 wins first
  - timer=0
  - Reset mid-transaction aborts it with no opAck.
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - If any ipReq bit is high, grant the first requester searching from (last+1) mod N_REQ upward with wrap.
  - Latch that requester's write, address and data; record grant; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - opBusValid=1 for exactly this cycle, with the latched op, address and data.
  - Write: go to DONE.
  - Read: clear timer and go to WAIT_RD.
- WAIT_RD:
  - ipBusRdValid=1: capture ipBusRdData into opRdData, opError=0, go to DONE.
  - Else if timer==TIMEOUT-1: opRdData=32'hDEAD_BEEF (ERR_PATTERN), opError=1, go to DONE.
  - Else timer++.
  - If ipBusRdValid coincides with the timeout cycle, the data wins and opError=0.
- DONE:
  - opAck[grant]=1 for one cycle; opError/opRdData valid; last=grant; go to IDLE.
  - opRdData holds its value until the next read completes.
  - Writes leave opRdData unchanged and drive opError=0.
- Latency:
  - Write: request sampled in IDLE at cycle 0, opBusValid at cycle 1, opAck at cycle 2.
  - Read: ack one cycle after ipBusRdValid is sampled; timeout ack at cycle TIMEOUT+2.
- Request rules:
  - Latched fields are not re-sampled, so input changes after the grant are ignored.
  - ipReq dropping mid-transaction does not cancel it; opAck is still issued.
  - ipReq still high in the IDLE cycle after DONE counts as a new request. The requester must deassert it on the cycle opAck is seen.
- Minimum spacing between bus strobes is 3 cycles; there is no back-to-back issue.
- ipBusRdValid outside WAIT_RD is ignored. Write transactions never wait on it.
- Fairness: with all requesters continuously requesting, each is granted once per N_REQ transactions.

Decomposition:
- Shared package Structures:
  - ARB_STATE enum (IDLE, ISSUE, WAIT_RD, DONE)
  - REG_REQUEST struct (Write, Address, WrData)
  - constant ERR_PATTERN = 32'hDEAD_BEEF
- Sub-module rr_priority:
  - combinational round-robin picker
  - inputs: request vector, last-grant index
  - outputs: grant index, grant-valid
  - parameterised by N_REQ; reused by future arbiters

Test Plan:
- Single write: req0 write addr 8'h10 data 32'h1234_5678 -> opBusValid at cycle 1 with those values, opBusWrite=1; opAck=2'b01 at cycle 2, opError=0.
- Read with data: req1 read addr 8'h04; ipBusRdValid with 32'hCAFE_F00D 3 cycles after the strobe -> opAck=2'b10 next cycle, opRdData=32'hCAFE_F00D, opError=0.
- Read timeout: req0 read, no ipBusRdValid, TIMEOUT=16 -> opAck=2'b01 at cycle 18, opRdData=32'hDEAD_BEEF, opError=1.
- Contention: req0 and req1 both held high for 4 transactions -> grant order 0,1,0,1; no opBusValid strobes closer than 3 cycles.
- Boundary: ipBusRdValid on the exact timeout cycle -> opError=0 with the data; stray ipBusRdValid while IDLE -> no output change.
- Reset mid-read: ipReset=0 during WAIT_RD -> next cycle all outputs 0, opBusy=0, no opAck; a following req1 read completes normally.

Source files
------------

// File: rtl/reg_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter_pkg
//   Shared types and constants for the register-bus arbiter.
//   - arb_state_e   : arbiter FSM states
//   - reg_request_t : one latched register request (op, address, write data)
//   - ERR_PATTERN   : read data returned when a read times out
//   The default bus widths live here so the struct and the arbiter agree.
// ---------------------------------------------------------------------------
package reg_bus_arbiter_pkg;

  localparam int REG_ADDR_W = 8;
  localparam int REG_DATA_W = 32;

  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [REG_ADDR_W-1:0] address;
    logic [REG_DATA_W-1:0] wr_data;
  } reg_request_t;

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter_if
//   Bundles the requester handshake and the register-bus signals of the
//   arbiter.
//   - master modport : requesters plus register block (drive ip*, see op*)
//   - slave modport  : the arbiter itself (sees ip*, drives op*)
//   Requester i owns bit i of ipReq/ipWrite/opAck and slice
//   [i*W +: W] of ipAddress/ipWrData.
// ---------------------------------------------------------------------------
interface reg_bus_arbiter_if
  import reg_bus_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
);

  logic [N_REQ-1:0]        ipReq;
  logic [N_REQ-1:0]        ipWrite;
  logic [N_REQ*ADDR_W-1:0] ipAddress;
  logic [N_REQ*DATA_W-1:0] ipWrData;
  logic [N_REQ-1:0]        opAck;
  logic                    opError;
  logic [DATA_W-1:0]       opRdData;
  logic                    opBusy;
  logic                    opBusValid;
  logic                    opBusWrite;
  logic [ADDR_W-1:0]       opBusAddress;
  logic [DATA_W-1:0]       opBusWrData;
  logic                    ipBusRdValid;
  logic [DATA_W-1:0]       ipBusRdData;

  modport master (
    output ipReq, ipWrite, ipAddress, ipWrData, ipBusRdValid, ipBusRdData,
    input  opAck, opError, opRdData, opBusy,
    input  opBusValid, opBusWrite, opBusAddress, opBusWrData
  );

  modport slave (
    input  ipReq, ipWrite, ipAddress, ipWrData, ipBusRdValid, ipBusRdData,
    output opAck, opError, opRdData, opBusy,
    output opBusValid, opBusWrite, opBusAddress, opBusWrData
  );

endinterface

// File: rtl/reg_bus_arbiter_rr_priority.sv
// ---------------------------------------------------------------------------
// rr_priority
//   Combinational round-robin picker.
//   - req   : request vector
//   - last  : index granted last time
//   - grant : first requesting index searching from last+1 upward, wrapping
//   - valid : at least one request is set
// ---------------------------------------------------------------------------
module rr_priority #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  int cand_s;

  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    grant  = '0;
    valid  = 1'b0;
    cand_s = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand_s = (int'(last) + i) % N_REQ;
      if (req[cand_s]) begin
        grant = IDX_W'(cand_s);
        valid = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter
//   Shares one register bus between N_REQ requesters, round-robin, one
//   transaction at a time. Reads wait up to TIMEOUT cycles for data and
//   otherwise complete with opError=1 and ERR_PATTERN.
//   - ipClk   : system clock
//   - ipReset : synchronous active-low reset
//   - bus     : requester handshake and register bus (slave modport)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                ipClk,
  input  logic                ipReset,
  reg_bus_arbiter_if.slave    bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  arb_state_e        state_r;
  arb_state_e        state_s;
  logic [IDX_W-1:0]  last_r;
  logic [IDX_W-1:0]  grant_r;
  logic [IDX_W-1:0]  pick_idx_s;
  logic              pick_valid_s;
  reg_request_t      req_r;
  logic [TMR_W-1:0]  timer_r;
  logic              timeout_s;

  logic [N_REQ-1:0]  ack_r;
  logic              error_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              busy_r;
  logic              bus_valid_r;
  logic              bus_write_r;
  logic [ADDR_W-1:0] bus_address_r;
  logic [DATA_W-1:0] bus_wr_data_r;

  rr_priority #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_priority (
    .req   (bus.ipReq),
    .last  (last_r),
    .grant (pick_idx_s),
    .valid (pick_valid_s)
  );

  assign timeout_s = (timer_r == TMR_W'(TIMEOUT - 1));

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) state_s = ISSUE;
        else              state_s = IDLE;
      end
      ISSUE: begin
        if (req_r.write) state_s = DONE;
        else             state_s = WAIT_RD;
      end
      WAIT_RD: begin
        if (bus.ipBusRdValid || timeout_s) state_s = DONE;
        else                               state_s = WAIT_RD;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ipClk) begin
    if (!ipReset) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Request latch, bus strobe, timer and response registers.
  // Each output is loaded on the transition into the state where it is valid.
  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      last_r        <= IDX_W'(N_REQ - 1);
      grant_r       <= '0;
      req_r         <= '0;
      timer_r       <= '0;
      ack_r         <= '0;
      error_r       <= 1'b0;
      rd_data_r     <= '0;
      busy_r        <= 1'b0;
      bus_valid_r   <= 1'b0;
      bus_write_r   <= 1'b0;
      bus_address_r <= '0;
      bus_wr_data_r <= '0;
    end else begin
      ack_r       <= '0;
      bus_valid_r <= 1'b0;
      busy_r      <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            grant_r         <= pick_idx_s;
            req_r.write     <= bus.ipWrite[pick_idx_s];
            req_r.address   <= REG_ADDR_W'(bus.ipAddress[pick_idx_s*ADDR_W +: ADDR_W]);
            req_r.wr_data   <= REG_DATA_W'(bus.ipWrData[pick_idx_s*DATA_W +: DATA_W]);
            bus_valid_r     <= 1'b1;
            bus_write_r     <= bus.ipWrite[pick_idx_s];
            bus_address_r   <= bus.ipAddress[pick_idx_s*ADDR_W +: ADDR_W];
            bus_wr_data_r   <= bus.ipWrData[pick_idx_s*DATA_W +: DATA_W];
          end else begin
            grant_r <= grant_r;
          end
        end
        ISSUE: begin
          timer_r <= '0;
          if (req_r.write) begin
            ack_r[grant_r] <= 1'b1;
            error_r        <= 1'b0;
          end else begin
            error_r <= error_r;
          end
        end
        WAIT_RD: begin
          // Data arriving on the timeout cycle takes priority over the error.
          if (bus.ipBusRdValid) begin
            rd_data_r      <= bus.ipBusRdData;
            error_r        <= 1'b0;
            ack_r[grant_r] <= 1'b1;
          end else if (timeout_s) begin
            rd_data_r      <= DATA_W'(ERR_PATTERN);
            error_r        <= 1'b1;
            ack_r[grant_r] <= 1'b1;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        DONE: begin
          last_r <= grant_r;
        end
        default: begin
          last_r <= last_r;
        end
      endcase
    end
  end

  assign bus.opAck        = ack_r;
  assign bus.opError      = error_r;
  assign bus.opRdData     = rd_data_r;
  assign bus.opBusy       = busy_r;
  assign bus.opBusValid   = bus_valid_r;
  assign bus.opBusWrite   = bus_write_r;
  assign bus.opBusAddress = bus_address_r;
  assign bus.opBusWrData  = bus_wr_data_r;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_arbiter
//   Directed bench for reg_bus_arbiter (N_REQ=2, ADDR_W=8, DATA_W=32,
//   TIMEOUT=16). Inputs change and outputs are sampled 1 time unit after
//   each rising edge.
// ---------------------------------------------------------------------------
module tb_reg_bus_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  reg_bus_arbiter_if #(.N_REQ(2), .ADDR_W(8), .DATA_W(32)) bus_if ();

  reg_bus_arbiter #(.N_REQ(2), .ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
    .ipClk   (clk),
    .ipReset (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   64'(bus_if.opAck), 64'd0);
    check({tag, "_err"},   64'(bus_if.opError), 64'd0);
    check({tag, "_rd"},    64'(bus_if.opRdData), 64'd0);
    check({tag, "_busy"},  64'(bus_if.opBusy), 64'd0);
    check({tag, "_bv"},    64'(bus_if.opBusValid), 64'd0);
    check({tag, "_bw"},    64'(bus_if.opBusWrite), 64'd0);
    check({tag, "_ba"},    64'(bus_if.opBusAddress), 64'd0);
    check({tag, "_bd"},    64'(bus_if.opBusWrData), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_if.ipReq        = 2'b00;
    bus_if.ipWrite      = 2'b00;
    bus_if.ipAddress    = 16'h0000;
    bus_if.ipWrData     = 64'h0;
    bus_if.ipBusRdValid = 1'b0;
    bus_if.ipBusRdData  = 32'h0;

    // Reset state.
    tick(); tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single write from requester 0.
    bus_if.ipReq     = 2'b01;
    bus_if.ipWrite   = 2'b01;
    bus_if.ipAddress = 16'h0010;
    bus_if.ipWrData  = {32'h0, 32'h1234_5678};
    tick();
    check("wr_bv",   64'(bus_if.opBusValid), 64'd1);
    check("wr_bw",   64'(bus_if.opBusWrite), 64'd1);
    check("wr_ba",   64'(bus_if.opBusAddress), 64'h10);
    check("wr_bd",   64'(bus_if.opBusWrData), 64'h1234_5678);
    check("wr_busy", 64'(bus_if.opBusy), 64'd1);
    check("wr_ack1", 64'(bus_if.opAck), 64'd0);
    tick();
    check("wr_ack",  64'(bus_if.opAck), 64'b01);
    check("wr_err",  64'(bus_if.opError), 64'd0);
    check("wr_bv2",  64'(bus_if.opBusValid), 64'd0);
    bus_if.ipReq = 2'b00;
    tick();
    check("wr_idle_ack",  64'(bus_if.opAck), 64'd0);
    check("wr_idle_busy", 64'(bus_if.opBusy), 64'd0);

    // Read from requester 1 with data 3 cycles after the strobe.
    bus_if.ipReq     = 2'b10;
    bus_if.ipWrite   = 2'b00;
    bus_if.ipAddress = 16'h0400;
    tick();
    check("rd_bv", 64'(bus_if.opBusValid), 64'd1);
    check("rd_bw", 64'(bus_if.opBusWrite), 64'd0);
    check("rd_ba", 64'(bus_if.opBusAddress), 64'h04);
    bus_if.ipReq     = 2'b00;
    bus_if.ipAddress = 16'hFFFF;
    tick();
    check("rd_bv_once", 64'(bus_if.opBusValid), 64'd0);
    tick();
    tick();
    bus_if.ipBusRdValid = 1'b1;
    bus_if.ipBusRdData  = 32'hCAFE_F00D;
    tick();
    bus_if.ipBusRdValid = 1'b0;
    check("rd_ack",  64'(bus_if.opAck), 64'b10);
    check("rd_data", 64'(bus_if.opRdData), 64'hCAFE_F00D);
    check("rd_err",  64'(bus_if.opError), 64'd0);
    tick();

    // Stray read strobe while idle changes nothing.
    bus_if.ipBusRdValid = 1'b1;
    bus_if.ipBusRdData  = 32'h1111_1111;
    tick();
    tick();
    bus_if.ipBusRdValid = 1'b0;
    check("stray_rd",   64'(bus_if.opRdData), 64'hCAFE_F00D);
    check("stray_ack",  64'(bus_if.opAck), 64'd0);
    check("stray_busy", 64'(bus_if.opBusy), 64'd0);
    check("stray_bv",   64'(bus_if.opBusValid), 64'd0);

    // Read timeout from requester 0: ack at cycle 18.
    bus_if.ipReq     = 2'b01;
    bus_if.ipAddress = 16'h0020;
    tick();
    check("to_bv", 64'(bus_if.opBusValid), 64'd1);
    bus_if.ipReq = 2'b00;
    for (int c = 2; c <= 17; c++) tick();
    check("to_ack17",  64'(bus_if.opAck), 64'd0);
    check("to_busy17", 64'(bus_if.opBusy), 64'd1);
    tick();
    check("to_ack",  64'(bus_if.opAck), 64'b01);
    check("to_data", 64'(bus_if.opRdData), 64'hDEAD_BEEF);
    check("to_err",  64'(bus_if.opError), 64'd1);
    tick();

    // Data on the exact timeout cycle wins over the error.
    bus_if.ipReq     = 2'b10;
    bus_if.ipAddress = 16'h0800;
    tick();
    check("edge_bv", 64'(bus_if.opBusValid), 64'd1);
    bus_if.ipReq = 2'b00;
    for (int c = 2; c <= 17; c++) tick();
    bus_if.ipBusRdValid = 1'b1;
    bus_if.ipBusRdData  = 32'h5A5A_A5A5;
    tick();
    bus_if.ipBusRdValid = 1'b0;
    check("edge_ack",  64'(bus_if.opAck), 64'b10);
    check("edge_err",  64'(bus_if.opError), 64'd0);
    check("edge_data", 64'(bus_if.opRdData), 64'h5A5A_A5A5);
    tick();

    // Contention: both requesters write continuously; order 0,1,0,1.
    bus_if.ipReq     = 2'b11;
    bus_if.ipWrite   = 2'b11;
    bus_if.ipAddress = 16'h3130;
    bus_if.ipWrData  = {32'hBBBB_0001, 32'hAAAA_0000};
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ct_bv", 64'(bus_if.opBusValid), 64'd1);
      check("ct_ba", 64'(bus_if.opBusAddress), (k % 2 == 0) ? 64'h30 : 64'h31);
      tick();
      check("ct_ack", 64'(bus_if.opAck), (k % 2 == 0) ? 64'b01 : 64'b10);
      check("ct_gap1", 64'(bus_if.opBusValid), 64'd0);
      if (k == 3) bus_if.ipReq = 2'b00;
      tick();
      check("ct_gap2", 64'(bus_if.opBusValid), 64'd0);
    end

    // Reset during WAIT_RD aborts with no ack.
    bus_if.ipReq     = 2'b01;
    bus_if.ipWrite   = 2'b00;
    bus_if.ipAddress = 16'h0040;
    tick();
    bus_if.ipReq = 2'b00;
    tick();
    tick();
    check("mr_busy_pre", 64'(bus_if.opBusy), 64'd1);
    rst_n = 1'b0;
    tick();
    check_all_zero("midrst");
    rst_n = 1'b1;
    tick();
    check("mr_ack_after", 64'(bus_if.opAck), 64'd0);

    // A following read from requester 1 completes normally.
    bus_if.ipReq     = 2'b10;
    bus_if.ipAddress = 16'h0C00;
    tick();
    check("post_bv", 64'(bus_if.opBusValid), 64'd1);
    check("post_ba", 64'(bus_if.opBusAddress), 64'h0C);
    bus_if.ipReq = 2'b00;
    tick();
    bus_if.ipBusRdValid = 1'b1;
    bus_if.ipBusRdData  = 32'h0BAD_F00D;
    tick();
    bus_if.ipBusRdValid = 1'b0;
    check("post_ack",  64'(bus_if.opAck), 64'b10);
    check("post_data", 64'(bus_if.opRdData), 64'h0BAD_F00D);
    check("post_err",  64'(bus_if.opError), 64'd0);
    tick();
    check("post_busy", 64'(bus_if.opBusy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
